// File: rtl/network_arbiter_state_ctrl.sv
// rtl/network_arbiter_state_ctrl.sv - trust-state write controller: validate, drain network, commit, respond.
// Optional: NET_ARB_TRANSITION_CNT_EN adds o_transition_cnt (saturating commit counter).
module network_arbiter_state_ctrl #(
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_data,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [1:0]  o_rsp_code,
  input  logic        i_net_busy,
  output logic [31:0] o_write_state_value,
  output logic        o_state_changing
`ifdef NET_ARB_TRANSITION_CNT_EN
  ,
  output logic [15:0] o_transition_cnt
`endif
);

  localparam int DW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [31:0] TRUSTED   = 32'h0000_0000;
  localparam logic [31:0] UNTRUSTED = 32'hF0F0_F0F0;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_SAME    = 2'b01;
  localparam logic [1:0] RSP_INVALID = 2'b10;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pending;
  logic [31:0]   r_wsv;
  logic [DW-1:0] r_drain_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_quiet;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [1:0]    r_rsp_code;
  logic          r_changing;

  logic [HW-1:0] w_hold_dec;
  logic          w_req_legal;
  logic          w_accept;

  always_comb begin
    w_hold_dec  = (r_hold_cnt != '0) ? (r_hold_cnt - 1'b1) : '0;
    w_req_legal = (i_req_data == TRUSTED) || (i_req_data == UNTRUSTED);
    w_accept    = i_req_valid && r_req_ready;
  end

  // Every output is a register; r_req_ready is precomputed from the next state and next hold value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_pending   <= TRUSTED;
      r_wsv       <= TRUSTED;
      r_drain_cnt <= '0;
      r_hold_cnt  <= '0;
      r_quiet     <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_code  <= RSP_OK;
      r_changing  <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_dec;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pending   <= i_req_data;
            r_req_ready <= 1'b0;
            if (!w_req_legal) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_code  <= RSP_INVALID;
            end else if (i_req_data == r_wsv) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_code  <= RSP_SAME;
            end else begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= '0;
              r_quiet     <= 1'b0;
              r_changing  <= 1'b1;
            end
          end else begin
            r_req_ready <= (w_hold_dec == '0);
          end
        end
        S_DRAIN: begin
          // Quiet wins over timeout when both land on the same cycle.
          if (!i_net_busy && r_quiet) begin
            r_state <= S_COMMIT;
          end else if (r_drain_cnt == DRAIN_LAST) begin
            r_state     <= S_RESP;
            r_changing  <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_code  <= RSP_TIMEOUT;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
            r_quiet     <= !i_net_busy;
          end
        end
        S_COMMIT: begin
          r_wsv       <= r_pending;
          r_hold_cnt  <= HOLD_LOAD;
          r_state     <= S_RESP;
          r_changing  <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_code  <= RSP_OK;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= (w_hold_dec == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef NET_ARB_TRANSITION_CNT_EN
  logic [15:0] r_transition_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_transition_cnt <= '0;
    end else if (r_state == S_COMMIT && r_transition_cnt != 16'hFFFF) begin
      r_transition_cnt <= r_transition_cnt + 16'd1;
    end
  end

  assign o_transition_cnt = r_transition_cnt;
`endif

  assign o_req_ready         = r_req_ready;
  assign o_rsp_valid         = r_rsp_valid;
  assign o_rsp_code          = r_rsp_code;
  assign o_write_state_value = r_wsv;
  assign o_state_changing    = r_changing;

endmodule

// File: tb/tb_network_arbiter_state_ctrl.sv
// tb/tb_network_arbiter_state_ctrl.sv - directed and randomized check against a transaction-level model.
module tb_network_arbiter_state_ctrl;

  localparam int DT   = 8;
  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_code;
  logic        net_busy;
  logic [31:0] wsv;
  logic        changing;
`ifdef NET_ARB_TRANSITION_CNT_EN
  logic [15:0] tcnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  network_arbiter_state_ctrl #(.DRAIN_TIMEOUT(DT), .HOLD_CYCLES(HOLD)) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_req_valid         (req_valid),
    .i_req_data          (req_data),
    .o_req_ready         (req_ready),
    .o_rsp_valid         (rsp_valid),
    .i_rsp_ready         (rsp_ready),
    .o_rsp_code          (rsp_code),
    .i_net_busy          (net_busy),
    .o_write_state_value (wsv),
    .o_state_changing    (changing)
`ifdef NET_ARB_TRANSITION_CNT_EN
    ,
    .o_transition_cnt    (tcnt)
`endif
  );

  always #5 clk = ~clk;

  // Transaction-level model: a request is either answered at once, or waits for a run of two
  // quiet samples within DT drain samples, followed by a one-cycle commit.
  bit          m_draining, m_committing, m_rsp, m_ready;
  int          m_hold, m_n, m_zeros, m_cnt;
  logic [1:0]  m_code;
  logic [31:0] m_wsv, m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_draining = 0; m_committing = 0; m_rsp = 0; m_ready = 0;
      m_hold = 0; m_n = 0; m_zeros = 0; m_cnt = 0;
      m_code = 2'b00; m_wsv = 32'h0; m_pend = 32'h0;
    end else begin
      if (m_hold > 0) m_hold--;
      if (m_rsp) begin
        if (rsp_ready) m_rsp = 0;
      end else if (m_committing) begin
        m_committing = 0;
        m_wsv = m_pend;
        m_hold = HOLD;
        m_rsp = 1; m_code = 2'b00;
        if (m_cnt < 65535) m_cnt++;
      end else if (m_draining) begin
        m_n++;
        m_zeros = net_busy ? 0 : m_zeros + 1;
        if (m_zeros >= 2) begin
          m_draining = 0; m_committing = 1;
        end else if (m_n == DT) begin
          m_draining = 0; m_rsp = 1; m_code = 2'b11;
        end
      end else if (m_ready && req_valid) begin
        if (req_data != 32'h0 && req_data != 32'hF0F0_F0F0) begin
          m_rsp = 1; m_code = 2'b10;
        end else if (req_data == m_wsv) begin
          m_rsp = 1; m_code = 2'b01;
        end else begin
          m_pend = req_data; m_draining = 1; m_n = 0; m_zeros = 0;
        end
      end
      m_ready = !(m_draining || m_committing || m_rsp) && (m_hold == 0);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    cmp(name, act, exp);
  endtask

  task automatic check_all();
    vectors++;
    cmp("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
    cmp("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rsp});
    if (m_rsp) cmp("rsp_code", {30'd0, rsp_code}, {30'd0, m_code});
    cmp("write_state_value", wsv, m_wsv);
    cmp("state_changing", {31'd0, changing}, {31'd0, m_draining || m_committing});
`ifdef NET_ARB_TRANSITION_CNT_EN
    cmp("transition_cnt", {16'd0, tcnt}, m_cnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    pin("wait_ready_bound", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic send(input logic [31:0] d);
    req_valid = 1'b1;
    req_data  = d;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_data = 32'h0; rsp_ready = 1'b1; net_busy = 1'b0;
    @(negedge clk);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    pin("t1_wsv", wsv, 32'h0);
    pin("t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    pin("t1_req_ready", {31'd0, req_ready}, 32'd1);

    send(32'hF0F0_F0F0);
    step(); step();
    pin("t2_wsv_before", wsv, 32'h0);
    step();
    pin("t2_wsv_e3", wsv, 32'hF0F0_F0F0);
    pin("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    pin("t2_rsp_code", {30'd0, rsp_code}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      pin("t2_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    wait_ready();

    send(32'h1234_5678);
    pin("t3_invalid_code", {30'd0, rsp_code}, 32'd2);
    step();
    pin("t3_ready_after", {31'd0, req_ready}, 32'd1);
    pin("t3_wsv", wsv, 32'hF0F0_F0F0);
    send(32'hF0F0_F0F0);
    pin("t3_same_code", {30'd0, rsp_code}, 32'd1);
    step();

    net_busy = 1'b1;
    send(32'h0);
    for (int i = 0; i < DT - 1; i++) begin
      step();
      pin("t4_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
    end
    step();
    pin("t4_timeout_valid", {31'd0, rsp_valid}, 32'd1);
    pin("t4_timeout_code", {30'd0, rsp_code}, 32'd3);
    pin("t4_wsv_kept", wsv, 32'hF0F0_F0F0);
    step();
    wait_ready();

    net_busy = 1'b0;
    send(32'h0);
    rsp_ready = 1'b0;
    net_busy = 1'b1; step();
    net_busy = 1'b0; step();
    net_busy = 1'b1; step();
    net_busy = 1'b0; step();
    net_busy = 1'b0; step();
    pin("t5_changing", {31'd0, changing}, 32'd1);
    pin("t5_wsv_pre", wsv, 32'hF0F0_F0F0);
    step();
    pin("t5_wsv_commit", wsv, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      pin("t5_rsp_held", {31'd0, rsp_valid}, 32'd1);
      pin("t5_code_held", {30'd0, rsp_code}, 32'd0);
      pin("t5_ready_low", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    wait_ready();
    send(32'h0);
    pin("t3_same_trusted", {30'd0, rsp_code}, 32'd1);
    step();

    send(32'hF0F0_F0F0);
    net_busy = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pin("t6_wsv", wsv, 32'h0);
    pin("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    pin("t6_changing", {31'd0, changing}, 32'd0);
`ifdef NET_ARB_TRANSITION_CNT_EN
    pin("t6_cnt_reset", {16'd0, tcnt}, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      req_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: req_data = 32'h0;
        1: req_data = 32'hF0F0_F0F0;
        2: req_data = 32'hF0F0_F0F0 ^ (32'h1 << $urandom_range(0, 31));
        default: req_data = $urandom;
      endcase
      net_busy  = ($urandom_range(0, 9) < (i % 500 < 250 ? 3 : 8));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
